ascii_display_scanner: RTL and testbench

- Time-multiplexes one combinational ASCII-to-segment decoder (`truthtable`: 7-bit code A..G in, 11 segment outputs Sa..Sk) across DIGITS character positions.
- Holds a small character buffer written through a valid/ready port.
- Scans the positions in a fixed order: present code, let the decoder settle, latch the segments, drive the one-hot digit select for a dwell period, blank, advance.
- Sits between the host/character source and the display pins; the decoder sits outside this block.

---
 rtl/ascii_display_scanner.sv | 146 ++++++++++++++
 tb/tb_ascii_display_scanner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_display_scanner.sv
// ascii_display_scanner
// Scans a small character buffer across 2**ADDR_W display positions. It
// shares one external ASCII-to-segment decoder between them: present the
// code, let the decoder settle for one cycle, latch the segments, light the
// digit for DWELL cycles, stay dark for BLANK cycles, then move on.
module ascii_display_scanner #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned DWELL   = 1000,
    parameter int unsigned BLANK   = 2,
    parameter int unsigned DWELL_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [6:0]             wr_char,
    output logic                   wr_ready,
    output logic [6:0]             dec_code,
    input  logic [10:0]            dec_seg,
    output logic [10:0]            seg_out,
    output logic [(2**ADDR_W)-1:0] digit_sel,
    output logic                   frame_tick
);

    localparam int unsigned        DIGITS   = 2**ADDR_W;
    localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL - 1);
    localparam logic [DWELL_W-1:0] BLANK_LD = DWELL_W'((BLANK > 0) ? (BLANK - 1) : 0);
    localparam logic [6:0]         SPACE    = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHOW,
        S_BLNK
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [DWELL_W-1:0]  r_cnt;
    logic [6:0]          r_dec_code;
    logic [10:0]         r_seg;
    logic [DIGITS-1:0]   r_digit_sel;
    logic                r_frame_tick;
    logic [6:0]          r_buf [DIGITS];

    logic                w_wr_ready;
    logic                w_wr_fire;
    logic                w_advance;
    logic [ADDR_W-1:0]   w_idx_next;
    logic [DIGITS-1:0]   w_onehot;

    // Handshake, advance condition and next-digit decode
    always_comb begin
        w_wr_ready = (r_state != S_SETUP);
        w_wr_fire  = wr_en && w_wr_ready;
        w_advance  = 1'b0;
        if (r_cnt == '0) begin
            if (r_state == S_BLNK) begin
                w_advance = 1'b1;
            end else if ((r_state == S_SHOW) && (BLANK == 0)) begin
                w_advance = 1'b1;
            end
        end
        w_idx_next = r_idx + ADDR_W'(1);
        w_onehot   = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
    end

    // Character buffer; reads elsewhere see the pre-edge contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                r_buf[i] <= SPACE;
            end
        end else if (w_wr_fire) begin
            r_buf[wr_addr] <= wr_char;
        end
    end

    // Scan FSM with registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_dec_code   <= SPACE;
            r_seg        <= '0;
            r_digit_sel  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if ((r_state != S_IDLE) && !enable) begin
                // Disable wins over expiry and wrap; idx kept for resume
                r_state     <= S_IDLE;
                r_seg       <= '0;
                r_digit_sel <= '0;
                r_cnt       <= '0;
            end else if (w_advance) begin
                // Advance leaves seg_out/digit_sel alone: with BLANK=0 the
                // previous digit stays lit through SETUP, so no dark gap.
                r_idx        <= w_idx_next;
                r_dec_code   <= r_buf[w_idx_next];
                r_frame_tick <= (w_idx_next == '0);
                r_state      <= S_SETUP;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_dec_code <= r_buf[r_idx];
                            r_state    <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        r_seg       <= dec_seg;
                        r_digit_sel <= w_onehot;
                        r_cnt       <= DWELL_LD;
                        r_state     <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (r_cnt == '0) begin
                            r_seg       <= '0;
                            r_digit_sel <= '0;
                            r_cnt       <= BLANK_LD;
                            r_state     <= S_BLNK;
                        end else begin
                            r_cnt <= r_cnt - DWELL_W'(1);
                        end
                    end
                    S_BLNK: begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_ready   = w_wr_ready;
    assign dec_code   = r_dec_code;
    assign seg_out    = r_seg;
    assign digit_sel  = r_digit_sel;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_ascii_display_scanner.sv
// Bench for ascii_display_scanner: a buffer/scan-order model predicts the
// code loaded at every SETUP, the digit shown after it, and the frame-tick
// cycles; a negedge monitor pops those predictions as the DUT presents them.
module tb_ascii_display_scanner;

    localparam int unsigned DW = 4;
    localparam int unsigned BL = 1;
    localparam int unsigned P  = 1 + DW + BL;
    localparam int unsigned ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (DWELL=4, BLANK=1)
    logic        rst_n, enable, wr_en;
    logic [1:0]  wr_addr;
    logic [6:0]  wr_char;
    logic        wr_ready;
    logic [6:0]  dec_code;
    logic [10:0] dec_seg, seg_out;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    // Second DUT (DWELL=1, BLANK=0), free-running
    logic        rst0_n;
    logic        wr_ready0;
    logic [6:0]  dec_code0;
    logic [10:0] dec_seg0, seg_out0;
    logic [3:0]  digit_sel0;
    logic        frame_tick0;

    // Stand-in for the external decoder; never yields an all-zero pattern
    function automatic logic [10:0] dec_model(input logic [6:0] c);
        return {c, c[3:0]} ^ 11'h3A5;
    endfunction

    assign dec_seg  = dec_model(dec_code);
    assign dec_seg0 = dec_model(dec_code0);

    ascii_display_scanner #(.ADDR_W(2), .DWELL(DW), .BLANK(BL), .DWELL_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .wr_ready(wr_ready),
        .dec_code(dec_code), .dec_seg(dec_seg), .seg_out(seg_out),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    ascii_display_scanner #(.ADDR_W(2), .DWELL(1), .BLANK(0), .DWELL_W(16)) dut0 (
        .clk(clk), .rst_n(rst0_n), .enable(1'b1), .wr_en(1'b0),
        .wr_addr(2'd0), .wr_char(7'h00), .wr_ready(wr_ready0),
        .dec_code(dec_code0), .dec_seg(dec_seg0), .seg_out(seg_out0),
        .digit_sel(digit_sel0), .frame_tick(frame_tick0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Model state
    typedef struct {
        int unsigned idx;
        logic [6:0]  code;
    } load_t;

    load_t       loadq[$];
    int unsigned tickq[$];
    logic [6:0]  m_buf [ND];
    int unsigned m_idx;
    bit          m_scan;
    int unsigned s;
    int unsigned cyc = 0;
    logic        en_s = 1'b0;
    bit          mon_on = 0, mon_rst = 0, mon0_on = 0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        en_s <= enable;
    end

    // Drive one edge's inputs and advance the model by that edge
    task automatic step(input bit en_i, input bit we_i, input logic [1:0] a_i,
                        input logic [6:0] c_i, output bit acc);
        int unsigned n;
        bit          rdy;
        n   = cyc + 1;
        rdy = !(m_scan && (((n - 1 - s) % P) == 0));
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, rdy});
        enable  = en_i;
        wr_en   = we_i;
        wr_addr = a_i;
        wr_char = c_i;
        if (!en_i) begin
            m_scan = 0;
        end else if (!m_scan) begin
            m_scan = 1;
            s      = n;
            loadq.push_back('{m_idx, m_buf[m_idx]});
        end else if (((n - s) % P) == 0) begin
            m_idx = (m_idx + 1) % ND;
            if (m_idx == 0) tickq.push_back(n);
            loadq.push_back('{m_idx, m_buf[m_idx]});
        end
        acc = we_i && rdy;
        if (acc) m_buf[a_i] = c_i;
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int unsigned k);
        bit acc;
        for (int unsigned i = 0; i < k; i++) step(1'b1, 1'b0, 2'd0, 7'h00, acc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_buf[i] = 7'h20;
        m_idx  = 0;
        m_scan = 0;
    endtask

    // Scoreboard monitor for the main DUT
    load_t       pend;
    bit          show_wait = 0, lit_on = 0;
    logic [3:0]  lit_sel;
    int unsigned lit_len;

    always @(negedge clk) begin
        if (mon_on) begin
            if (mon_rst) begin
                show_wait = 0;
                lit_on    = 0;
                lit_len   = 0;
                mon_rst   = 0;
            end
            chk("onehot0", {31'd0, ((digit_sel & (digit_sel - 4'd1)) == 4'd0)}, 32'd1);
            chk("dark_seg", {31'd0, ((seg_out == '0) || (digit_sel != '0))}, 32'd1);
            if (show_wait) begin
                show_wait = 0;
                if (en_s) begin
                    chk("show_digit", {28'd0, digit_sel}, 32'd1 << pend.idx);
                    chk("show_seg", {21'd0, seg_out}, {21'd0, dec_model(pend.code)});
                    lit_on  = 1;
                    lit_sel = digit_sel;
                    lit_len = 1;
                end
            end else if (lit_on) begin
                if (digit_sel == lit_sel) begin
                    lit_len++;
                end else begin
                    lit_on = 0;
                    if (en_s) chk("dwell_len", lit_len, DW);
                end
            end
            if (!wr_ready) begin
                if (loadq.size() == 0) begin
                    fail("setup_unexpected");
                end else begin
                    pend = loadq.pop_front();
                    chk("dec_code", {25'd0, dec_code}, {25'd0, pend.code});
                    show_wait = 1;
                end
            end
            if (frame_tick) begin
                if (tickq.size() == 0) fail("tick_unexpected");
                else chk("tick_cycle", cyc, tickq.pop_front());
            end else if ((tickq.size() > 0) && (tickq[0] < cyc)) begin
                fail("tick_missing");
                void'(tickq.pop_front());
            end
        end
    end

    // Monitor for the gap-free instance
    logic [3:0]  prev0 = '0;
    int unsigned len0 = 0, last_tick0 = 0;
    bit          have_tick0 = 0, have_prev0 = 0;

    always @(negedge clk) begin
        if (mon0_on) begin
            chk("onehot0_b0", {31'd0, ((digit_sel0 & (digit_sel0 - 4'd1)) == 4'd0)}, 32'd1);
            chk("dark_seg_b0", {31'd0, ((seg_out0 == '0) || (digit_sel0 != '0))}, 32'd1);
            if (frame_tick0) begin
                if (have_tick0) chk("tick_period_b0", cyc - last_tick0, 32'd8);
                have_tick0 = 1;
                last_tick0 = cyc;
            end
            if (have_prev0) chk("nogap_b0", {31'd0, (digit_sel0 != '0)}, 32'd1);
            if (digit_sel0 != prev0) begin
                if ((prev0 != '0) && (digit_sel0 != '0)) begin
                    chk("rotate_b0", {28'd0, digit_sel0}, {28'd0, prev0[2:0], prev0[3]});
                    if (have_prev0) chk("lit_b0", len0, 32'd2);
                    have_prev0 = 1;
                end
                len0  = 1;
                prev0 = digit_sel0;
            end else begin
                len0++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc, pend_w, en_r;
        logic [1:0]  pa;
        logic [6:0]  pc;
        int unsigned off_left;
        logic [6:0]  hola [4];

        rst_n = 1'b0; rst0_n = 1'b0; enable = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_char = '0;
        model_reset();
        hola[0] = 7'h48; hola[1] = 7'h4F; hola[2] = 7'h4C; hola[3] = 7'h41;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_dec_code", {25'd0, dec_code}, 32'h20);
        chk("rst_seg_out", {21'd0, seg_out}, 32'd0);
        chk("rst_digit_sel", {28'd0, digit_sel}, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        rst_n = 1'b1; rst0_n = 1'b1;
        mon_on = 1; mon0_on = 1;

        // Default buffer scan
        run(60);
        step(1'b0, 1'b0, 2'd0, 7'h00, acc);
        step(1'b0, 1'b0, 2'd0, 7'h00, acc);

        // Load HOLA while idle, then scan
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), hola[i], acc);
        run(50);

        // Write held across a SETUP cycle
        for (int k = 0; k < 20 && !(m_scan && (((cyc - s) % P) == 0)); k++) run(1);
        if (!(m_scan && (((cyc - s) % P) == 0))) fail("wait_setup");
        step(1'b1, 1'b1, 2'd0, 7'h33, acc);
        step(1'b1, 1'b1, 2'd0, 7'h33, acc);

        // Write to the digit currently being shown
        for (int k = 0; k < 40 && !(m_scan && m_idx == 2 && (((cyc - s) % P) == 2)); k++) run(1);
        if (!(m_scan && m_idx == 2 && (((cyc - s) % P) == 2))) fail("wait_show2");
        step(1'b1, 1'b1, 2'd2, 7'h5A, acc);
        run(30);

        // Enable drop mid-SHOW of digit 1, then resume
        for (int k = 0; k < 40 && !(m_scan && m_idx == 1 && (((cyc - s) % P) == 2)); k++) run(1);
        if (!(m_scan && m_idx == 1 && (((cyc - s) % P) == 2))) fail("wait_show1");
        step(1'b0, 1'b0, 2'd0, 7'h00, acc);
        chk("drop_digit_sel", {28'd0, digit_sel}, 32'd0);
        chk("drop_seg_out", {21'd0, seg_out}, 32'd0);
        chk("drop_frame_tick", {31'd0, frame_tick}, 32'd0);
        step(1'b0, 1'b0, 2'd0, 7'h00, acc);
        step(1'b0, 1'b0, 2'd0, 7'h00, acc);
        run(20);

        // Random writes and enable drops
        pend_w = 0; en_r = 1; off_left = 0; pa = '0; pc = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend_w && ($urandom_range(0, 3) == 0)) begin
                pend_w = 1;
                pa = 2'($urandom_range(0, 3));
                pc = 7'($urandom_range(0, 127));
            end
            if (en_r && ($urandom_range(0, 99) == 0)) begin
                en_r = 0;
                off_left = $urandom_range(1, 5);
            end else if (!en_r) begin
                off_left--;
                if (off_left == 0) en_r = 1;
            end
            step(en_r, pend_w, pa, pc, acc);
            if (acc) pend_w = 0;
        end

        // Asynchronous reset between edges while a digit is lit
        for (int k = 0; k < 50 && !(m_scan && (((cyc - s) % P) == 2)); k++) run(1);
        if (!(m_scan && (((cyc - s) % P) == 2))) fail("wait_show_rst");
        rst_n = 1'b0;
        #1;
        chk("arst_digit_sel", {28'd0, digit_sel}, 32'd0);
        chk("arst_seg_out", {21'd0, seg_out}, 32'd0);
        chk("arst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("arst_dec_code", {25'd0, dec_code}, 32'h20);
        rst_n = 1'b1;
        model_reset();
        mon_rst = 1;
        run(40);

        // Drain
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 7'h00, acc);
        chk("loadq_drained", loadq.size(), 32'd0);
        chk("tickq_drained", tickq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
